// File: rtl/pipe_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, skid buffer, IF/ID latch.
// Define DELAY_SLOT_EN to deliver the post-branch instruction as a delay slot.
module pipe_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] ra,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] pc,
   output logic [31:0] dpc4,
   output logic [31:0] inst,
   output logic        dvalid
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      SQUASH = 2'd2
   } state_t;

   state_t      state;
   state_t      state_n;
   logic        run;
   logic [31:0] pc_n;
   logic [31:0] addr_n;
   logic [31:0] inst_n;
   logic [31:0] dpc4_n;
   logic        dvalid_n;
   logic [31:0] skid_inst;
   logic [31:0] skid_inst_n;
   logic [31:0] skid_pc4;
   logic [31:0] skid_pc4_n;
   logic [31:0] pend;
   logic [31:0] pend_n;
   logic        accept;
   logic        redirect;
   logic        ack;
   logic [31:0] addr4;
   logic [31:0] target;

   // run keeps the request low for one cycle after reset so a stale ack is dropped
   assign imem_req = run & (state != HOLD);
   assign ack      = imem_req & imem_ack;
   assign addr4    = imem_addr + 32'd4;
   assign accept   = ~dvalid | ~stall;
   assign redirect = dvalid & ~stall & (pcsource != 2'b00);

   always_comb begin
      target = pc;
      unique case (pcsource)
         2'b01:   target = bpc;
         2'b10:   target = ra;
         2'b11:   target = jpc;
         default: target = pc;
      endcase
   end

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      addr_n      = imem_addr;
      inst_n      = inst;
      dpc4_n      = dpc4;
      dvalid_n    = dvalid;
      skid_inst_n = skid_inst;
      skid_pc4_n  = skid_pc4;
      pend_n      = pend;
      unique case (state)
         FETCH: begin
            if (ack) begin
               if (redirect) begin
                  pc_n   = target;
                  addr_n = target;
`ifdef DELAY_SLOT_EN
                  inst_n   = imem_rdata;
                  dpc4_n   = addr4;
                  dvalid_n = 1'b1;
`else
                  dvalid_n = 1'b0;
`endif
               end else if (accept) begin
                  inst_n   = imem_rdata;
                  dpc4_n   = addr4;
                  dvalid_n = 1'b1;
                  pc_n     = addr4;
                  addr_n   = addr4;
               end else begin
                  skid_inst_n = imem_rdata;
                  skid_pc4_n  = addr4;
                  state_n     = HOLD;
               end
            end else if (redirect) begin
               pc_n     = target;
               pend_n   = target;
               dvalid_n = 1'b0;
               state_n  = SQUASH;
            end else if (accept) begin
               dvalid_n = 1'b0;
            end
         end
         HOLD: begin
            if (!stall) begin
               state_n = FETCH;
               if (redirect) begin
                  pc_n   = target;
                  addr_n = target;
`ifdef DELAY_SLOT_EN
                  inst_n   = skid_inst;
                  dpc4_n   = skid_pc4;
                  dvalid_n = 1'b1;
`else
                  dvalid_n = 1'b0;
`endif
               end else begin
                  inst_n   = skid_inst;
                  dpc4_n   = skid_pc4;
                  dvalid_n = 1'b1;
                  pc_n     = skid_pc4;
                  addr_n   = skid_pc4;
               end
            end
         end
         SQUASH: begin
            if (ack) begin
               addr_n  = pend;
               state_n = FETCH;
`ifdef DELAY_SLOT_EN
               inst_n   = imem_rdata;
               dpc4_n   = addr4;
               dvalid_n = 1'b1;
`else
               dvalid_n = 1'b0;
`endif
            end else if (accept) begin
               dvalid_n = 1'b0;
            end
         end
         default: state_n = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= FETCH;
         run       <= 1'b0;
         pc        <= RESET_PC;
         imem_addr <= RESET_PC;
         inst      <= 32'h0;
         dpc4      <= 32'h0;
         dvalid    <= 1'b0;
         skid_inst <= 32'h0;
         skid_pc4  <= 32'h0;
         pend      <= 32'h0;
      end else begin
         state     <= state_n;
         run       <= 1'b1;
         pc        <= pc_n;
         imem_addr <= addr_n;
         inst      <= inst_n;
         dpc4      <= dpc4_n;
         dvalid    <= dvalid_n;
         skid_inst <= skid_inst_n;
         skid_pc4  <= skid_pc4_n;
         pend      <= pend_n;
      end
   end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed bench for pipe_fetch_unit; memory returns address XOR TAG.
// Honours DELAY_SLOT_EN for the redirect scenarios.
module tb_pipe_fetch_unit;
   localparam logic [31:0] TAG = 32'h5A00_0000;

   logic        clk = 1'b0;
   logic        clr;
   logic [1:0]  pcsource;
   logic [31:0] bpc, jpc, ra;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] pc, dpc4, inst;
   logic        dvalid;

   int passed = 0;
   int total  = 0;

   pipe_fetch_unit dut (
      .clk(clk), .clr(clr), .pcsource(pcsource), .bpc(bpc), .jpc(jpc),
      .ra(ra), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc(pc), .dpc4(dpc4),
      .inst(inst), .dvalid(dvalid)
   );

   always #5 clk = ~clk;
   always_comb imem_rdata = imem_addr ^ TAG;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      clr = 1'b1; imem_ack = 1'b0; stall = 1'b0; pcsource = 2'b00;
      tick; tick;
      clr = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      clr = 1'b1; imem_ack = 1'b0; stall = 1'b0; pcsource = 2'b00;
      bpc = 32'h0; jpc = 32'h0; ra = 32'h0;
      tick; tick;
      total++; if (pc !== 32'h0) $display("FAIL rst_pc got %h want %h", pc, 32'h0); else passed++;
      total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h want %h", imem_addr, 32'h0); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else passed++;
      total++; if (dvalid !== 1'b0) $display("FAIL rst_dvalid got %b want 0", dvalid); else passed++;
      total++; if ({inst, dpc4} !== 64'h0) $display("FAIL rst_ifid got %h/%h want 0/0", inst, dpc4); else passed++;
      clr = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0) $display("FAIL rst_req_fall got %b want 0", imem_req); else passed++;
      tick;
      total++; if (imem_req !== 1'b1) $display("FAIL rst_req_run got %b want 1", imem_req); else passed++;
   endtask

   task automatic test_sequential;
      imem_ack = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick;
         total++;
         if (imem_addr !== 32'(4 * k) || dpc4 !== 32'(4 * k) || dvalid !== 1'b1 ||
             inst !== (32'(4 * (k - 1)) ^ TAG))
            $display("FAIL seq_%0d got addr=%h dpc4=%h v=%b inst=%h want addr=%h", k,
                     imem_addr, dpc4, dvalid, inst, 32'(4 * k));
         else passed++;
      end
   endtask

   task automatic test_stall;
      stall = 1'b1;
      tick;
      imem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (imem_req !== 1'b0 || dvalid !== 1'b1 || dpc4 !== 32'h10 ||
             inst !== (32'hC ^ TAG) || pc !== 32'h10)
            $display("FAIL stall_hold_%0d got req=%b v=%b dpc4=%h inst=%h pc=%h want req=0 dpc4=10",
                     k, imem_req, dvalid, dpc4, inst, pc);
         else passed++;
         if (k < 2) tick;
      end
      stall = 1'b0;
      tick;
      total++;
      if (dvalid !== 1'b1 || dpc4 !== 32'h14 || inst !== (32'h10 ^ TAG))
         $display("FAIL stall_release got v=%b dpc4=%h inst=%h want dpc4=14", dvalid, dpc4, inst);
      else passed++;
      total++;
      if (imem_addr !== 32'h14 || imem_req !== 1'b1)
         $display("FAIL stall_next got addr=%h req=%b want 14/1", imem_addr, imem_req);
      else passed++;
   endtask

   task automatic test_branch;
      imem_ack = 1'b1; pcsource = 2'b01; bpc = 32'h40;
      tick;
      pcsource = 2'b00;
      total++; if (imem_addr !== 32'h40) $display("FAIL br_addr got %h want 40", imem_addr); else passed++;
      total++; if (pc !== 32'h40) $display("FAIL br_pc got %h want 40", pc); else passed++;
`ifdef DELAY_SLOT_EN
      total++;
      if (dvalid !== 1'b1 || inst !== (32'h14 ^ TAG) || dpc4 !== 32'h18)
         $display("FAIL br_slot got v=%b inst=%h dpc4=%h want slot 14", dvalid, inst, dpc4);
      else passed++;
`else
      total++; if (dvalid !== 1'b0) $display("FAIL br_drop got v=%b want 0", dvalid); else passed++;
`endif
      tick;
      total++;
      if (dvalid !== 1'b1 || inst !== (32'h40 ^ TAG) || dpc4 !== 32'h44 || imem_addr !== 32'h44)
         $display("FAIL br_target got v=%b inst=%h dpc4=%h addr=%h want 40 target", dvalid, inst, dpc4, imem_addr);
      else passed++;
   endtask

   task automatic test_jump;
      do_reset;
      imem_ack = 1'b1;
      for (int k = 0; k < 5; k++) tick;
      total++; if (imem_addr !== 32'h14 || dpc4 !== 32'h14) $display("FAIL jmp_setup got addr=%h dpc4=%h want 14/14", imem_addr, dpc4); else passed++;
      imem_ack = 1'b0; pcsource = 2'b11; jpc = 32'h100;
      tick;
      pcsource = 2'b00;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (imem_addr !== 32'h14 || imem_req !== 1'b1 || dvalid !== 1'b0 || pc !== 32'h100)
            $display("FAIL jmp_squash_%0d got addr=%h req=%b v=%b pc=%h want 14/1/0/100", k, imem_addr, imem_req, dvalid, pc);
         else passed++;
         if (k == 0) tick;
      end
      imem_ack = 1'b1;
      tick;
      total++; if (imem_addr !== 32'h100) $display("FAIL jmp_addr got %h want 100", imem_addr); else passed++;
`ifdef DELAY_SLOT_EN
      total++; if (dvalid !== 1'b1 || inst !== (32'h14 ^ TAG)) $display("FAIL jmp_slot got v=%b inst=%h want slot 14", dvalid, inst); else passed++;
`else
      total++; if (dvalid !== 1'b0) $display("FAIL jmp_drop got v=%b want 0", dvalid); else passed++;
`endif
      tick;
      total++;
      if (dvalid !== 1'b1 || inst !== (32'h100 ^ TAG) || dpc4 !== 32'h104)
         $display("FAIL jmp_target got v=%b inst=%h dpc4=%h want 100 target", dvalid, inst, dpc4);
      else passed++;
   endtask

   task automatic test_wrap;
      imem_ack = 1'b1; pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
      tick;
      pcsource = 2'b00;
      total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_setup got %h want fffffffc", imem_addr); else passed++;
      tick;
      total++;
      if (imem_addr !== 32'h0 || dpc4 !== 32'h0 || pc !== 32'h0 || inst !== (32'hFFFF_FFFC ^ TAG))
         $display("FAIL wrap got addr=%h dpc4=%h pc=%h inst=%h want 0/0/0", imem_addr, dpc4, pc, inst);
      else passed++;
   endtask

   task automatic test_ra_bubble;
      imem_ack = 1'b0; pcsource = 2'b10; ra = 32'h200;
      tick;
      pcsource = 2'b00;
      total++; if (pc !== 32'h200 || dvalid !== 1'b0) $display("FAIL ra_pc got pc=%h v=%b want 200/0", pc, dvalid); else passed++;
      imem_ack = 1'b1;
      tick;
      total++; if (imem_addr !== 32'h200) $display("FAIL ra_addr got %h want 200", imem_addr); else passed++;
      tick;
      total++; if (inst !== (32'h200 ^ TAG) || dpc4 !== 32'h204) $display("FAIL ra_target got inst=%h dpc4=%h want 200 target", inst, dpc4); else passed++;
      imem_ack = 1'b0;
      tick;
      total++;
      if (dvalid !== 1'b0 || imem_addr !== 32'h204 || imem_req !== 1'b1)
         $display("FAIL bubble got v=%b addr=%h req=%b want 0/204/1", dvalid, imem_addr, imem_req);
      else passed++;
      imem_ack = 1'b1;
      tick;
      imem_ack = 1'b0; stall = 1'b1; pcsource = 2'b01; bpc = 32'h999;
      tick;
      total++;
      if (dvalid !== 1'b1 || dpc4 !== 32'h208 || pc !== 32'h208 || imem_addr !== 32'h208)
         $display("FAIL stall_ignore got v=%b dpc4=%h pc=%h addr=%h want 1/208/208/208", dvalid, dpc4, pc, imem_addr);
      else passed++;
      pcsource = 2'b00;
   endtask

   task automatic test_reset_mid;
      clr = 1'b1; imem_ack = 1'b1; stall = 1'b1;
      tick;
      clr = 1'b0; stall = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0) $display("FAIL midrst_req got %b want 0", imem_req); else passed++;
      tick;
      total++;
      if (dvalid !== 1'b0 || imem_addr !== 32'h0 || inst !== 32'h0)
         $display("FAIL midrst_ack got v=%b addr=%h inst=%h want 0/0/0", dvalid, imem_addr, inst);
      else passed++;
      tick;
      total++;
      if (dvalid !== 1'b1 || inst !== TAG || dpc4 !== 32'h4)
         $display("FAIL midrst_first got v=%b inst=%h dpc4=%h want 1/%h/4", dvalid, inst, dpc4, TAG);
      else passed++;
   endtask

   initial begin
      test_reset;
      test_sequential;
      test_stall;
      test_branch;
      test_jump;
      test_wrap;
      test_ra_bubble;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/pipe_fetch_unit.md
PIPE_FETCH_UNIT -- requirements
Module: pipe_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have ports (one per line, clock and reset first):
  clk  in  1  single clock; all state updates on rising edge
  clr  in  1  reset, synchronous, active-high
  pcsource  in  2  next-PC select from decode: 00 PC+4, 01 bpc, 10 ra, 11 jpc
  bpc  in  32  branch target from decode
  jpc  in  32  jump target from decode
  ra  in  32  register-jump target from decode
  stall  in  1  decode load-use stall; IF/ID hold request
  imem_req  out  1  instruction memory request
  imem_addr  out  32  word address of request
  imem_rdata  in  32  instruction returned
  imem_ack  in  1  imem_rdata valid; completes current request
  pc  out  32  address of next fetch
  dpc4  out  32  IF/ID: address of held instruction plus 4
  inst  out  32  IF/ID: held instruction
  dvalid  out  1  IF/ID: inst/dpc4 valid

Function
REQ-003 SHALL keep at most one memory request outstanding; imem_req and imem_addr stable from assertion until the imem_ack cycle.
REQ-004 SHALL implement FSM states FETCH (imem_req=1), HOLD (instruction buffered, imem_req=0), SQUASH (imem_req=1, return to be discarded).
REQ-005 SHALL define accept = ~dvalid | ~stall; redirect = dvalid & ~stall & (pcsource != 00).
REQ-006 SHALL compute all address arithmetic modulo 2^32; PC+4 at 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-007 SHALL, in FETCH on imem_ack with accept=1 and no redirect, load inst<=imem_rdata, dpc4<=imem_addr+4, dvalid<=1, pc<=imem_addr+4, next request same cycle+1.
REQ-008 SHALL, in FETCH on imem_ack with accept=0, store data in a one-entry skid buffer, enter HOLD, drop imem_req.
REQ-009 SHALL, in HOLD when stall deasserts, move skid buffer to IF/ID and return to FETCH on the following cycle.
REQ-010 SHALL, when accept=1 and no ack arrives, clear dvalid to 0 (bubble).
REQ-011 SHALL, on redirect, select target by pcsource and set pc<=target; new target request issued once current request completes.
REQ-012 SHALL, on redirect with no ack that cycle, latch target in a pending register and enter SQUASH until ack.
REQ-013 SHALL, with redirect and imem_ack coincident, treat the returned instruction per REQ-019.
REQ-014 SHALL hold pc, dpc4, inst, dvalid unchanged while dvalid=1 and stall=1.
REQ-015 SHALL ignore pcsource when dvalid=0 or stall=1.

Reset
REQ-016 SHALL, on clr=1 at a rising edge, set pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, inst=32'h0, dpc4=32'h0, dvalid=0, skid and pending registers empty, FSM=FETCH; imem_req=1 from first cycle after clr falls.
REQ-017 SHALL, on clr mid-request, abandon the outstanding request; an imem_ack in the cycle after reset is ignored.
REQ-018 SHALL give clr priority over stall, redirect and imem_ack.

Configuration
REQ-019 SHALL honour macro DELAY_SLOT_EN: defined -- the instruction fetched after a redirecting branch/jump (in flight or coincident) is a delay slot, delivered to IF/ID with dvalid=1 before the target; undefined -- that instruction is discarded, dvalid=0 for that cycle, target fetched next.
REQ-020 SHALL not alter any other behaviour with DELAY_SLOT_EN.

Verification
REQ-021 Reset then imem_ack=1 every cycle, stall=0 -> imem_addr 0x0,0x4,0x8; dvalid=1 from 2nd cycle; dpc4 0x4,0x8.
REQ-022 stall=1 for 3 cycles with dvalid=1, ack on first -> IF/ID unchanged, imem_req=0 in HOLD; buffered inst appears cycle after stall=0, no instruction lost/duplicated.
REQ-023 Branch at 0x10, pcsource=01, bpc=0x40, coincident ack of 0x14 -> undefined macro: 0x14 dropped, next imem_addr=0x40; DELAY_SLOT_EN: 0x14 delivered, then 0x40.
REQ-024 Jump pcsource=11, jpc=0x100, ack delayed 2 cycles -> SQUASH held, imem_addr stable at 0x14 until ack, then 0x100.
REQ-025 pc=0xFFFF_FFFC, sequential fetch -> next imem_addr=0x0, dpc4=0x0.
REQ-026 clr=1 while request outstanding and ack in following cycle -> ack ignored, dvalid=0, imem_addr=RESET_PC.
